// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control unit: sequences fetch/decode/execute/memory/writeback
// through imem/dmem handshakes and drives the datapath control strobes.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zflag,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        reg_write,
    output logic        ALUSrc,
    output logic        Loadsrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUcontrol,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    state_t     state;
    logic [6:0] ir_op;
    logic [2:0] ir_f3;
    logic       ir_b30;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_bne;

    logic       dec_legal;
    logic       dec_alusrc;
    logic       dec_load;
    logic       dec_store;
    logic       dec_branch;
    logic [1:0] dec_imm;
    logic [3:0] dec_alu;

    // Only opcode, funct3 and bit 30 steer control; the rest belongs to the datapath.
    logic instr_unused;
    assign instr_unused = ^{instr[31], instr[29:15], instr[11:7]};

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic b30,
                                           input logic rtype);
        case (f3)
            3'b000:  return (rtype && b30) ? 4'b0001 : 4'b0000;
            3'b001:  return 4'b0110;
            3'b010:  return 4'b0101;
            3'b011:  return 4'b1001;
            3'b100:  return 4'b0100;
            3'b101:  return b30 ? 4'b1000 : 4'b0111;
            3'b110:  return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    always_comb begin
        dec_legal  = 1'b0;
        dec_alusrc = 1'b0;
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        dec_branch = 1'b0;
        dec_imm    = 2'b00;
        dec_alu    = 4'b0000;
        case (ir_op)
            7'b0110011: begin
                dec_legal = 1'b1;
                dec_alu   = alu_sel(ir_f3, ir_b30, 1'b1);
            end
            7'b0010011: begin
                dec_legal  = 1'b1;
                dec_alusrc = 1'b1;
                dec_alu    = alu_sel(ir_f3, ir_b30, 1'b0);
            end
            7'b0000011: begin
                dec_legal  = 1'b1;
                dec_alusrc = 1'b1;
                dec_load   = 1'b1;
            end
            7'b0100011: begin
                dec_legal  = 1'b1;
                dec_alusrc = 1'b1;
                dec_store  = 1'b1;
                dec_imm    = 2'b01;
            end
            7'b1100011: begin
                if (ir_f3[2:1] == 2'b00) begin
                    dec_legal  = 1'b1;
                    dec_branch = 1'b1;
                    dec_imm    = 2'b10;
                    dec_alu    = 4'b0001;
                end
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ir_op      <= 7'd0;
            ir_f3      <= 3'd0;
            ir_b30     <= 1'b0;
            is_load    <= 1'b0;
            is_store   <= 1'b0;
            is_branch  <= 1'b0;
            is_bne     <= 1'b0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            reg_write  <= 1'b0;
            Loadsrc    <= 1'b0;
            ALUSrc     <= 1'b0;
            ImmSrc     <= 2'b00;
            ALUcontrol <= 4'b0000;
            illegal    <= 1'b0;
            instret    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        ir_op    <= instr[6:0];
                        ir_f3    <= instr[14:12];
                        ir_b30   <= instr[30];
                        imem_req <= 1'b0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_legal) begin
                        ALUSrc     <= dec_alusrc;
                        ImmSrc     <= dec_imm;
                        ALUcontrol <= dec_alu;
                        is_load    <= dec_load;
                        is_store   <= dec_store;
                        is_branch  <= dec_branch;
                        is_bne     <= ir_f3[0];
                        state      <= EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= TRAP;
                    end
                end
                EXEC: begin
                    if (is_branch) begin
                        instret    <= instret + 32'd1;
                        ALUSrc     <= 1'b0;
                        ImmSrc     <= 2'b00;
                        ALUcontrol <= 4'b0000;
                        imem_req   <= 1'b1;
                        state      <= FETCH;
                    end else if (is_load || is_store) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= is_store;
                        state    <= MEM;
                    end else begin
                        reg_write <= 1'b1;
                        state     <= WB;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (is_store) begin
                            instret    <= instret + 32'd1;
                            ALUSrc     <= 1'b0;
                            ImmSrc     <= 2'b00;
                            ALUcontrol <= 4'b0000;
                            imem_req   <= 1'b1;
                            state      <= FETCH;
                        end else begin
                            reg_write <= 1'b1;
                            Loadsrc   <= 1'b1;
                            state     <= WB;
                        end
                    end
                end
                WB: begin
                    reg_write  <= 1'b0;
                    Loadsrc    <= 1'b0;
                    instret    <= instret + 32'd1;
                    ALUSrc     <= 1'b0;
                    ImmSrc     <= 2'b00;
                    ALUcontrol <= 4'b0000;
                    imem_req   <= 1'b1;
                    state      <= FETCH;
                end
                TRAP: state <= TRAP;
                default: state <= IDLE;
            endcase
        end
    end

    // Ack- and flag-dependent strobes must land in the same cycle as the event itself.
    assign ir_write = (state == FETCH) && imem_ack;
    assign pc_write = (state == WB) || ((state == EXEC) && is_branch) ||
                      ((state == MEM) && is_store && dmem_ack);
    assign pc_src   = (state == EXEC) && is_branch && (is_bne ? ~Zflag : Zflag);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: drives handshakes with random latencies and
// compares every output each cycle against an instruction-level reference model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        Zflag = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we, reg_write, ALUSrc, Loadsrc;
    logic [1:0]  ImmSrc;
    logic [3:0]  ALUcontrol;
    logic        ir_write, pc_write, pc_src, illegal;
    logic [31:0] instret;

    int          total = 0;
    int          bad = 0;
    logic [31:0] modelRet = 32'd0;
    bit          relPending = 1'b0;

    typedef enum {K_R, K_I, K_LD, K_ST, K_BR, K_BAD} kind_e;
    typedef struct {
        kind_e      kind;
        logic       alusrc;
        logic [1:0] imm;
        logic [3:0] alu;
        logic       bne;
    } ref_t;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .Zflag(Zflag),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_write(reg_write), .ALUSrc(ALUSrc), .Loadsrc(Loadsrc),
        .ImmSrc(ImmSrc), .ALUcontrol(ALUcontrol),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    // Instruction-level meaning: mnemonic table indexed by funct3, then the two bit-30 variants.
    function automatic ref_t refDecode(input logic [31:0] w);
        logic [3:0] aluByF3 [8];
        logic [2:0] f3;
        ref_t r;
        aluByF3 = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
        f3 = w[14:12];
        r.kind = K_BAD; r.alusrc = 1'b0; r.imm = 2'b00; r.alu = 4'd0; r.bne = 1'b0;
        if (w[6:0] == 7'h33) begin
            r.kind = K_R;
            r.alu = aluByF3[f3];
            if (w[30] && f3 == 3'd0) r.alu = 4'd1;
            if (w[30] && f3 == 3'd5) r.alu = 4'd8;
        end else if (w[6:0] == 7'h13) begin
            r.kind = K_I; r.alusrc = 1'b1;
            r.alu = aluByF3[f3];
            if (w[30] && f3 == 3'd5) r.alu = 4'd8;
        end else if (w[6:0] == 7'h03) begin
            r.kind = K_LD; r.alusrc = 1'b1;
        end else if (w[6:0] == 7'h23) begin
            r.kind = K_ST; r.alusrc = 1'b1; r.imm = 2'b01;
        end else if (w[6:0] == 7'h63 && f3 < 3'd2) begin
            r.kind = K_BR; r.imm = 2'b10; r.alu = 4'd1; r.bne = f3[0];
        end
        return r;
    endfunction

    function automatic logic [31:0] genInstr();
        logic [31:0] w;
        logic [6:0]  op;
        int          pick;
        w = $urandom;
        pick = int'($urandom_range(0, 11));
        case (pick)
            0, 1: w[6:0] = 7'h33;
            2, 3: w[6:0] = 7'h13;
            4, 5: w[6:0] = 7'h03;
            6, 7: w[6:0] = 7'h23;
            8, 9: begin
                w[6:0] = 7'h63;
                w[14:12] = 3'($urandom_range(0, 1));
            end
            10: begin
                op = 7'($urandom);
                if (op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63}) op = 7'h7F;
                w[6:0] = op;
            end
            default: begin
                w[6:0] = 7'h63;
                w[14:12] = 3'($urandom_range(2, 7));
            end
        endcase
        return w;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ia, input logic da, input logic [31:0] w,
                                 input logic z);
        imem_ack = ia;
        dmem_ack = da;
        instr    = w;
        Zflag    = z;
    endtask

    task automatic checkCycle(input string ph, input logic eImreq, input logic eIrw,
                              input logic eDreq, input logic eDwe, input logic eRegw,
                              input logic ePcw, input logic ePcsrc, input logic eLd,
                              input logic eAlusrc, input logic [1:0] eImm,
                              input logic [3:0] eAlu, input logic eIll);
        checkOutput({ph, ".imem_req"},   32'(imem_req),   32'(eImreq));
        checkOutput({ph, ".ir_write"},   32'(ir_write),   32'(eIrw));
        checkOutput({ph, ".dmem_req"},   32'(dmem_req),   32'(eDreq));
        checkOutput({ph, ".dmem_we"},    32'(dmem_we),    32'(eDwe));
        checkOutput({ph, ".reg_write"},  32'(reg_write),  32'(eRegw));
        checkOutput({ph, ".pc_write"},   32'(pc_write),   32'(ePcw));
        checkOutput({ph, ".pc_src"},     32'(pc_src),     32'(ePcsrc));
        checkOutput({ph, ".Loadsrc"},    32'(Loadsrc),    32'(eLd));
        checkOutput({ph, ".ALUSrc"},     32'(ALUSrc),     32'(eAlusrc));
        checkOutput({ph, ".ImmSrc"},     32'(ImmSrc),     32'(eImm));
        checkOutput({ph, ".ALUcontrol"}, 32'(ALUcontrol), 32'(eAlu));
        checkOutput({ph, ".illegal"},    32'(illegal),    32'(eIll));
        checkOutput({ph, ".instret"},    instret,         modelRet);
    endtask

    task automatic zeroCheck(input string ph, input logic eIll);
        checkCycle(ph, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, eIll);
    endtask

    task automatic resetPulse(input string ph);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 0, 32'd0, 0);
        #1;
        modelRet = 32'd0;
        zeroCheck({ph, ".rst"}, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        zeroCheck({ph, ".idle"}, 1'b0);
    endtask

    // One instruction from its first FETCH cycle to retirement, trap or abort.
    task automatic runInstr(input logic [31:0] w, input int fw, input int mw, input logic z,
                            input int abortAt);
        ref_t r;
        logic br, st, ld, ack;
        r  = refDecode(w);
        br = (r.kind == K_BR);
        st = (r.kind == K_ST);
        ld = (r.kind == K_LD);

        for (int i = 0; i <= fw; i++) begin
            @(negedge clk);
            ack = (i == fw);
            applyStimulus(ack, rbit(), ack ? w : $urandom, rbit());
            #1;
            checkCycle("fetch", 1, ack, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0);
        end

        @(negedge clk);
        applyStimulus(rbit(), rbit(), $urandom, rbit());
        if (relPending) begin
            release dut.instret;
            relPending = 1'b0;
        end
        #1;
        zeroCheck("decode", 1'b0);

        if (r.kind == K_BAD) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                applyStimulus(rbit(), rbit(), $urandom, rbit());
                #1;
                zeroCheck("trap", 1'b1);
            end
            resetPulse("trap");
            return;
        end

        @(negedge clk);
        applyStimulus(rbit(), rbit(), $urandom, z);
        #1;
        checkCycle("exec", 0, 0, 0, 0, 0, br, br & (r.bne ? ~z : z), 0,
                   r.alusrc, r.imm, r.alu, 0);
        if (br) begin
            modelRet = modelRet + 32'd1;
            return;
        end

        if (ld || st) begin
            for (int i = 0; i <= mw; i++) begin
                @(negedge clk);
                ack = (i == mw);
                applyStimulus(rbit(), ack, $urandom, rbit());
                #1;
                checkCycle("mem", 0, 0, 1, st, 0, st & ack, 0, 0, r.alusrc, r.imm, r.alu, 0);
                if (i == abortAt) begin
                    #2;
                    rst = 1'b1;
                    #1;
                    modelRet = 32'd0;
                    checkOutput("abort.dmem_req", 32'(dmem_req), 32'd0);
                    checkOutput("abort.dmem_we", 32'(dmem_we), 32'd0);
                    checkOutput("abort.instret", instret, modelRet);
                    @(negedge clk);
                    rst = 1'b0;
                    #1;
                    zeroCheck("abort.idle", 1'b0);
                    return;
                end
            end
            if (st) begin
                modelRet = modelRet + 32'd1;
                return;
            end
        end

        @(negedge clk);
        applyStimulus(rbit(), rbit(), $urandom, rbit());
        #1;
        checkCycle("wb", 0, 0, 0, 0, 1, 1, 0, ld, r.alusrc, r.imm, r.alu, 0);
        modelRet = modelRet + 32'd1;
    endtask

    initial begin
        applyStimulus(0, 0, 32'd0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        zeroCheck("reset", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        zeroCheck("idle", 1'b0);

        runInstr(32'h002081B3, 2, 0, 1'b0, -1);
        runInstr(32'h0080A283, 0, 0, 1'b0, -1);
        runInstr(32'h0020A223, 1, 2, 1'b0, -1);
        runInstr(32'h00108063, 0, 0, 1'b1, -1);
        runInstr(32'h00109063, 0, 0, 1'b1, -1);

        // Counter wrap: park instret at all-ones, then retire one branch.
        force dut.instret = 32'hFFFF_FFFF;
        modelRet = 32'hFFFF_FFFF;
        relPending = 1'b1;
        runInstr(32'h00108063, 1, 0, 1'b0, -1);
        runInstr(32'h002081B3, 0, 0, 1'b0, -1);

        runInstr(32'h0080A283, 1, 3, 1'b0, 1);

        for (int n = 0; n < 60; n++) begin
            runInstr(genInstr(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     rbit(), -1);
        end

        runInstr(32'h0000007F, 0, 0, 1'b0, -1);
        runInstr(32'h002081B3, 0, 0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports `clk`, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port `rst`, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port `instr`, input, 32 bits: instruction word, sampled when imem_ack=1 in FETCH.
REQ-004 SHALL have port `Zflag`, input, 1 bit: datapath ALU zero flag, sampled in EXEC.
REQ-005 SHALL have handshake ports `imem_req` (output, 1), `imem_ack` (input, 1), `dmem_req` (output, 1), `dmem_we` (output, 1) and `dmem_ack` (input, 1).
REQ-006 SHALL have datapath controls `reg_write` (output, 1), `ALUSrc` (output, 1), `Loadsrc` (output, 1), `ImmSrc` (output, 2) and `ALUcontrol` (output, 4).
REQ-007 SHALL have `ir_write` (output, 1, instruction-register load), `pc_write` (output, 1) and `pc_src` (output, 1; 0=PC+4, 1=PCTarget).
REQ-008 SHALL have `illegal` (output, 1, sticky trap flag) and `instret` (output, 32, retired-instruction count).

Function
REQ-009 SHALL implement the FSM states IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-010 IDLE SHALL last exactly one cycle after reset release and then go to FETCH.
REQ-011 FETCH SHALL hold imem_req=1 until imem_ack=1.
REQ-012 On the imem_ack cycle, FETCH SHALL pulse ir_write=1 for one cycle, latch instr internally and go to DECODE; no timeout applies.
REQ-013 DECODE SHALL last one cycle and decode opcode instr[6:0].
REQ-014 DECODE SHALL accept the following opcodes and send all others to TRAP: 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 with funct3 000/001 (BEQ/BNE).
REQ-015 ImmSrc encoding SHALL be 00=I, 01=S, 10=B; 11 SHALL be unused and never driven.
REQ-016 ALUcontrol encoding SHALL be 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu.
REQ-017 R-type SHALL use funct3 plus instr[30] to select sub/sra; I-ALU SHALL use instr[30] only for srai.
REQ-018 ALU function SHALL be add for LOAD/STORE and sub for branches.
REQ-019 ALUSrc SHALL be 1 for I-ALU, LOAD and STORE, and 0 otherwise.
REQ-020 ALUSrc, ImmSrc and ALUcontrol SHALL be registered in DECODE and held stable from EXEC through the end of MEM/WB; they SHALL be 0 in IDLE, FETCH and TRAP.
REQ-021 EXEC SHALL last one cycle; R/I-ALU SHALL go to WB and LOAD/STORE SHALL go to MEM.
REQ-022 For a branch, EXEC SHALL assert pc_write=1 with pc_src=(BEQ ? Zflag : ~Zflag), retire the instruction, and go to FETCH.
REQ-023 MEM SHALL hold dmem_req=1 (and dmem_we=1 for STORE) until dmem_ack=1.
REQ-024 On dmem_ack, STORE SHALL assert pc_write=1, pc_src=0, retire and go to FETCH; LOAD SHALL go to WB.
REQ-025 WB SHALL last one cycle with reg_write=1, pc_write=1, pc_src=0, Loadsrc=(LOAD ? 1 : 0), retire, then go to FETCH.
REQ-026 A write to rd=x0 SHALL still assert reg_write; the register file discards it.
REQ-027 ir_write, pc_write and reg_write SHALL each be one-cycle pulses, never asserted in the same state except pc_write with reg_write in WB.
REQ-028 "Retire" SHALL increment instret by 1 modulo 2^32 (0xFFFFFFFF wraps to 0).
REQ-029 TRAP SHALL set illegal=1, drive every other control output to 0, and hold until reset; instret SHALL be frozen and the illegal instruction not counted.
REQ-030 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-031 An ack arriving in the same cycle as the request's first assertion SHALL complete the access (minimum FETCH and MEM length is 1 cycle).

Reset
REQ-032 While rst=1, regardless of clock, state SHALL be IDLE and all outputs SHALL be 0, including illegal=0 and instret=0.
REQ-033 Reset asserted mid-access (FETCH/MEM) SHALL drop imem_req/dmem_req immediately and abandon the access; the first post-reset cycle SHALL be IDLE.

Verification
REQ-034 Fetch `add x3,x1,x2` (0x002081B3) with imem_ack after 2 wait cycles -> imem_req high 3 cycles, ir_write 1 pulse, then DECODE, EXEC (ALUcontrol=0000, ALUSrc=0), WB (reg_write=1, pc_write=1, pc_src=0); instret 0->1.
REQ-035 `lw x5,8(x1)` (0x0080A283) with dmem_ack in the first MEM cycle -> ImmSrc=00, ALUSrc=1, ALUcontrol=0000, dmem_req 1 cycle, dmem_we=0, WB with Loadsrc=1; total 5 cycles with a zero-wait fetch.
REQ-036 `sw x2,4(x1)` (0x0020A223) -> ImmSrc=01, dmem_we=1, no reg_write, pc_write at ack.
REQ-037 `beq x1,x1` with Zflag=1 -> pc_src=1; `bne` with Zflag=1 -> pc_src=0; both ImmSrc=10, ALUcontrol=0001, and both return to FETCH after EXEC.
REQ-038 Opcode 0x0000007F -> TRAP, illegal=1, all other outputs 0 for 10 cycles, instret unchanged; then rst pulse -> illegal=0 and IDLE.
REQ-039 Preload instret to 0xFFFFFFFF via retirements (or force) and retire once -> instret=0; rst asserted during a MEM wait -> dmem_req falls asynchronously.
